wmem_pingpong_ctrl: RTL and testbench

Double-buffer (ping-pong) controller for the 64 KiB weight memory, split as two 32 KiB buffers.
- Sequences the 32-bit external write port into the buffer being filled.
- Hands the other, full buffer to the MAC array for compute.
- Swaps roles when a load and a compute have both completed.
- Sits between the external write port/DMA, the weight SRAM write interface and the control unit.

---
 rtl/wmem_pingpong_ctrl.sv | 167 ++++++++++++++++
 tb/tb_wmem_pingpong_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wmem_pingpong_ctrl.sv
// Ping-pong controller for the weight SRAM: fills one 32 KiB half from the write port
// while the MAC array computes from the other half; the halves swap once both sides finish.
module wmem_pingpong_ctrl #(
    parameter int MEM_ADDR_W = 16,
    parameter int PORT_W     = 32,
    parameter int LEN_W      = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  abort_i,
    input  logic                  load_start_i,
    input  logic [LEN_W-1:0]      load_len_i,
    output logic                  load_ready_o,
    input  logic                  wr_valid_i,
    input  logic [PORT_W-1:0]     wr_data_i,
    output logic                  wr_ready_o,
    output logic                  wmem_we_o,
    output logic [MEM_ADDR_W-1:0] wmem_addr_o,
    output logic [PORT_W-1:0]     wmem_wdata_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic                  cmp_ready_o,
    input  logic                  cmp_start_i,
    input  logic                  cmp_done_i,
    output logic                  cmp_bank_o,
    output logic [3:0]            bank_state_o
);
    // One half of the memory holds 2^CNT_W port words.
    localparam int               CNT_W   = MEM_ADDR_W - 3;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** CNT_W);

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_IN_USE  = 2'd3
    } buf_state_e;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_FILL = 1'b1
    } ld_state_e;

    ld_state_e             ld_state_q, ld_state_d;
    buf_state_e            buf_q [2];
    buf_state_e            buf_d [2];
    logic                  ld_ptr_q, ld_ptr_d;
    logic                  cmp_ptr_q, cmp_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  we_q, we_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [PORT_W-1:0]     wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  load_ready;
    logic                  wr_fire;

    assign load_ready = (ld_state_q == LD_IDLE) && (buf_q[ld_ptr_q] == BUF_EMPTY);
    assign wr_fire    = (ld_state_q == LD_FILL) && wr_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_state_q <= LD_IDLE;
            buf_q[0]   <= BUF_EMPTY;
            buf_q[1]   <= BUF_EMPTY;
            ld_ptr_q   <= 1'b0;
            cmp_ptr_q  <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            ld_ptr_q   <= ld_ptr_d;
            cmp_ptr_q  <= cmp_ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        buf_d      = buf_q;
        ld_ptr_d   = ld_ptr_q;
        cmp_ptr_d  = cmp_ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (load_start_i && load_ready) begin
            if (load_len_i == '0 || load_len_i > MAX_LEN) begin
                err_d = 1'b1;
            end else begin
                len_d            = load_len_i;
                cnt_d            = '0;
                buf_d[ld_ptr_q]  = BUF_FILLING;
                ld_state_d       = LD_FILL;
            end
        end

        if (wr_fire) begin
            we_d    = 1'b1;
            addr_d  = {ld_ptr_q, cnt_q, 2'b00};
            wdata_d = wr_data_i;
            if (LEN_W'(cnt_q) == len_q - LEN_W'(1)) begin
                buf_d[ld_ptr_q] = BUF_FULL;
                done_d          = 1'b1;
                ld_ptr_d        = ~ld_ptr_q;
                ld_state_d      = LD_IDLE;
                cnt_d           = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The compute side only acts on FULL/IN_USE buffers, so it never collides
        // with the load side, which only touches EMPTY/FILLING ones.
        if (cmp_start_i && buf_q[cmp_ptr_q] == BUF_FULL) begin
            buf_d[cmp_ptr_q] = BUF_IN_USE;
        end else if (cmp_done_i && buf_q[cmp_ptr_q] == BUF_IN_USE) begin
            buf_d[cmp_ptr_q] = BUF_EMPTY;
            cmp_ptr_d        = ~cmp_ptr_q;
        end

        if (abort_i) begin
            ld_state_d = LD_IDLE;
            buf_d[0]   = BUF_EMPTY;
            buf_d[1]   = BUF_EMPTY;
            ld_ptr_d   = 1'b0;
            cmp_ptr_d  = 1'b0;
            cnt_d      = '0;
            len_d      = '0;
            we_d       = 1'b0;
            addr_d     = '0;
            wdata_d    = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    assign load_ready_o = load_ready;
    assign wr_ready_o   = (ld_state_q == LD_FILL);
    assign wmem_we_o    = we_q;
    assign wmem_addr_o  = addr_q;
    assign wmem_wdata_o = wdata_q;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;
    assign cmp_ready_o  = (buf_q[cmp_ptr_q] == BUF_FULL);
    assign cmp_bank_o   = cmp_ptr_q;
    assign bank_state_o = {buf_q[1], buf_q[0]};

endmodule

// File: tb/tb_wmem_pingpong_ctrl.sv
// Randomized bench for wmem_pingpong_ctrl: a transaction-level buffer model predicts SRAM
// writes and done/err pulses into queues that an independent monitor drains.
module tb_wmem_pingpong_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        load_start;
    logic [13:0] load_len;
    logic        load_ready;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wmem_we;
    logic [15:0] wmem_addr;
    logic [31:0] wmem_wdata;
    logic        load_done;
    logic        load_err;
    logic        cmp_ready;
    logic        cmp_start;
    logic        cmp_done;
    logic        cmp_bank;
    logic [3:0]  bank_state;

    wmem_pingpong_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .abort_i      (abort),
        .load_start_i (load_start),
        .load_len_i   (load_len),
        .load_ready_o (load_ready),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .wmem_we_o    (wmem_we),
        .wmem_addr_o  (wmem_addr),
        .wmem_wdata_o (wmem_wdata),
        .load_done_o  (load_done),
        .load_err_o   (load_err),
        .cmp_ready_o  (cmp_ready),
        .cmp_start_i  (cmp_start),
        .cmp_done_i   (cmp_done),
        .cmp_bank_o   (cmp_bank),
        .bank_state_o (bank_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wq [$];
    int  evq [$];          // 1 = load_done pulse, 2 = load_err pulse
    int  nvec = 0;
    int  nmis = 0;

    // Model: per-buffer state (0 empty, 1 filling, 2 full, 3 in use) and the two pointers.
    int  ms [2];
    int  ml;
    int  mc;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        ms[0] = 0; ms[1] = 0; ml = 0; mc = 0;
    endfunction

    function automatic void model_cmp(input bit st, input bit dn);
        if (st && ms[mc] == 2) ms[mc] = 3;
        else if (dn && ms[mc] == 3) begin
            ms[mc] = 0;
            mc     = mc ^ 1;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (wmem_we) begin
                if (wq.size() == 0) chk("unexpected_write", 32'(wmem_addr), 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(wmem_addr), 32'(w.a));
                    chk("wr_data", wmem_wdata, w.d);
                end
            end
            if (load_done) begin
                if (evq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("done_event", 32'd1, 32'(evq.pop_front()));
            end
            if (load_err) begin
                if (evq.size() == 0) chk("unexpected_err", 32'd2, 32'd0);
                else chk("err_event", 32'd2, 32'(evq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":bank_state"}, 32'(bank_state), 32'(ms[1] * 4 + ms[0]));
        chk({tag, ":cmp_ready"},  32'(cmp_ready),  32'(ms[mc] == 2));
        chk({tag, ":cmp_bank"},   32'(cmp_bank),   32'(mc));
        chk({tag, ":load_ready"}, 32'(load_ready), 32'(ms[ml] == 0));
        chk({tag, ":wr_ready"},   32'(wr_ready),   32'd0);
    endtask

    // cend: 0 none, 1 cmp_start, 2 cmp_done, driven alongside the final word.
    task automatic do_load(input int len, input int dbase, input int gap_pct, input int cend);
        bit ok;
        wr_t w;
        ok         = (ms[ml] == 0);
        load_start = 1'b1;
        load_len   = 14'(len);
        tick();
        load_start = 1'b0;
        if (!ok) return;
        if (len == 0 || len > 8192) begin
            evq.push_back(2);
            return;
        end
        ms[ml] = 1;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = (dbase >= 0) ? 32'(dbase + i) : $urandom;
            w.a = 16'(ml * 32768 + i * 4);
            w.d = wr_data;
            wq.push_back(w);
            if (i == len - 1) begin
                cmp_start = (cend == 1);
                cmp_done  = (cend == 2);
                model_cmp(cend == 1, cend == 2);
            end
            tick();
        end
        wr_valid  = 1'b0;
        cmp_start = 1'b0;
        cmp_done  = 1'b0;
        evq.push_back(1);
        ms[ml] = 2;
        ml     = ml ^ 1;
    endtask

    // Optionally races a load_start that must be ignored because the fill buffer is busy.
    task automatic do_cmp(input bit st, input bit dn, input bit race_start);
        cmp_start = st;
        cmp_done  = dn;
        if (race_start && ms[ml] != 0) begin
            load_start = 1'b1;
            load_len   = 14'd3;
        end
        model_cmp(st, dn);
        tick();
        cmp_start  = 1'b0;
        cmp_done   = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic do_abort(input int len, input int nwords);
        wr_t w;
        if (ms[ml] == 0) begin
            load_start = 1'b1;
            load_len   = 14'(len);
            tick();
            load_start = 1'b0;
            for (int i = 0; i < nwords; i++) begin
                wr_valid = 1'b1;
                wr_data  = $urandom;
                w.a = 16'(ml * 32768 + i * 4);
                w.d = wr_data;
                wq.push_back(w);
                tick();
            end
        end
        abort    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = $urandom;
        tick();
        abort    = 1'b0;
        wr_valid = 1'b0;
        model_reset();
    endtask

    task automatic idle_noise(input int k);
        for (int i = 0; i < k; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        int len;
        rst_n = 1'b0; abort = 1'b0; load_start = 1'b0; load_len = '0;
        wr_valid = 1'b0; wr_data = '0; cmp_start = 1'b0; cmp_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst:we",         32'(wmem_we),    32'd0);
        chk("rst:done",       32'(load_done),  32'd0);
        chk("rst:err",        32'(load_err),   32'd0);
        chk("rst:cmp_ready",  32'(cmp_ready),  32'd0);
        chk("rst:bank_state", 32'(bank_state), 32'd0);
        chk("rst:wr_ready",   32'(wr_ready),   32'd0);
        chk("rst:addr",       32'(wmem_addr),  32'd0);
        rst_n = 1'b1;
        tick();
        check_state("after_reset");

        do_load(4, 'hA0, 0, 0);      check_state("load_a");
        do_load(2, 'hB0, 0, 0);      check_state("load_b");
        do_cmp(1'b1, 1'b0, 1'b0);    check_state("cmp_start0");
        do_cmp(1'b0, 1'b1, 1'b1);    check_state("cmp_done0");
        do_load(0, -1, 0, 0);        check_state("len_zero");
        do_load(8193, -1, 0, 0);     check_state("len_8193");
        do_load(3, 'hC0, 60, 0);     check_state("gapped");
        do_cmp(1'b1, 1'b0, 1'b0);
        do_cmp(1'b0, 1'b1, 1'b0);    check_state("release1");
        do_abort(5, 2);              check_state("abort");
        do_load(1, 'hD0, 0, 0);      check_state("post_abort");
        do_load(8192, -1, 0, 0);     check_state("max_len");
        idle_noise(4);               check_state("noise");

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    case ($urandom_range(0, 9))
                        0:       len = 0;
                        1:       len = 8193 + $urandom_range(0, 5000);
                        default: len = $urandom_range(1, 6);
                    endcase
                    do_load(len, -1, $urandom_range(0, 40), $urandom_range(0, 2));
                end
                4, 5:    do_cmp(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                6, 7:    do_cmp(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                8:       idle_noise($urandom_range(1, 3));
                default: if ($urandom_range(0, 3) == 0) do_abort(4, $urandom_range(1, 3));
            endcase
            check_state("rand");
        end

        repeat (3) tick();
        chk("writes_left", 32'(wq.size()),  32'd0);
        chk("events_left", 32'(evq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
